// File: rtl/vga_glyph_string.sv
// vga_glyph_string: renders a row of NUM_CHARS monochrome GW x GH glyphs into
// the VGA pixel stream. A power-on sweep blanks the screen; each start then
// blanks the string's bounding box and draws every glyph bit at the latched
// origin and colour. All outputs are registered: the pixel computed from the
// current state/counters appears one cycle later.
// Optional feature macro: GLYPH_SCALE2_EN (draw each glyph bit as a 2x2 block).
module vga_glyph_string #(
  parameter int unsigned GW        = 12,
  parameter int unsigned GH        = 12,
  parameter int unsigned NUM_CHARS = 3,
  parameter int unsigned XW        = 8,
  parameter int unsigned YW        = 7,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_CHARS*GW*GH-1:0]  glyphs,
  input  logic [XW-1:0]               x,
  input  logic [YW-1:0]               y,
  input  logic [2:0]                  colour_in,
  output logic                        busy,
  output logic                        done,
  output logic [XW-1:0]               x_out,
  output logic [YW-1:0]               y_out,
  output logic                        writeEn,
  output logic [2:0]                  colour
);

`ifdef GLYPH_SCALE2_EN
  localparam int unsigned SC = 2;
`else
  localparam int unsigned SC = 1;
`endif
  localparam int unsigned P    = NUM_CHARS * GW * GH;
  localparam int unsigned BW   = NUM_CHARS * GW * SC;
  localparam int unsigned BH   = GH * SC;
  localparam int unsigned SUBL = SC * SC - 1;

  typedef enum logic [2:0] {
    S_FULLCLR = 3'd0,
    S_IDLE    = 3'd1,
    S_CLEAR   = 3'd2,
    S_DRAW    = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     col_q, col_d, row_q, row_d, chr_q, chr_d;
  logic [1:0]      sub_q, sub_d;
  logic [P-1:0]    glyph_q, glyph_d;
  logic [XW-1:0]   xo_q, xo_d;
  logic [YW-1:0]   yo_q, yo_d;
  logic [2:0]      fg_q, fg_d;
  logic            busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [XW-1:0]   xout_q, xout_d;
  logic [YW-1:0]   yout_q, yout_d;
  logic [2:0]      colour_q, colour_d;

  // State, counters, latched string and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FULLCLR;
      col_q    <= '0;
      row_q    <= '0;
      chr_q    <= '0;
      sub_q    <= '0;
      glyph_q  <= '0;
      xo_q     <= '0;
      yo_q     <= '0;
      fg_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      xout_q   <= '0;
      yout_q   <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      chr_q    <= chr_d;
      sub_q    <= sub_d;
      glyph_q  <= glyph_d;
      xo_q     <= xo_d;
      yo_q     <= yo_d;
      fg_q     <= fg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      xout_q   <= xout_d;
      yout_q   <= yout_d;
      colour_q <= colour_d;
    end
  end

  // Next-state, scan counters and the pixel to present next cycle
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    chr_d    = chr_q;
    sub_d    = sub_q;
    glyph_d  = glyph_q;
    xo_d     = xo_q;
    yo_d     = yo_q;
    fg_d     = fg_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    we_d     = 1'b0;
    xout_d   = '0;
    yout_d   = '0;
    colour_d = '0;
    unique case (state_q)
      S_FULLCLR: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        xout_d = XW'(col_q);
        yout_d = YW'(row_q);
        if (col_q == 16'(SCREEN_W - 1)) begin
          col_d = '0;
          if (row_q == 16'(SCREEN_H - 1)) begin
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + 16'd1;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (start) begin
          glyph_d = glyphs;
          xo_d    = x;
          yo_d    = y;
          fg_d    = colour_in;
          col_d   = '0;
          row_d   = '0;
          chr_d   = '0;
          sub_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        xout_d = XW'(32'(xo_q) + 32'(col_q));
        yout_d = YW'(32'(yo_q) + 32'(row_q));
        if (col_q == 16'(BW - 1)) begin
          col_d = '0;
          if (row_q == 16'(BH - 1)) begin
            row_d   = '0;
            state_d = S_DRAW;
          end else begin
            row_d = row_q + 16'd1;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      S_DRAW: begin
        // glyph_q is shifted MSB-first, which matches the char/row/column scan
        busy_d   = 1'b1;
        we_d     = glyph_q[P-1];
        colour_d = fg_q;
        xout_d   = XW'(32'(xo_q) + 32'(chr_q) * GW * SC + 32'(col_q) * SC + 32'(sub_q[0]));
        yout_d   = YW'(32'(yo_q) + 32'(row_q) * SC + 32'(sub_q[1]));
        if (sub_q == 2'(SUBL)) begin
          sub_d   = '0;
          glyph_d = {glyph_q[P-2:0], 1'b0};
          if (col_q == 16'(GW - 1)) begin
            col_d = '0;
            if (row_q == 16'(GH - 1)) begin
              row_d = '0;
              if (chr_q == 16'(NUM_CHARS - 1)) begin
                chr_d   = '0;
                state_d = S_FIN;
              end else begin
                chr_d = chr_q + 16'd1;
              end
            end else begin
              row_d = row_q + 16'd1;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_FULLCLR;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign writeEn = we_q;
  assign x_out   = xout_q;
  assign y_out   = yout_q;
  assign colour  = colour_q;

endmodule

// File: tb/tb_vga_glyph_string.sv
// Directed bench for vga_glyph_string (default build, 1:1 pixel mapping).
module tb_vga_glyph_string;

  localparam int P  = 432;
  localparam int BW = 36;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [P-1:0]   glyphs;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour_in;
  logic           busy, done, writeEn;
  logic [7:0]     x_out;
  logic [6:0]     y_out;
  logic [2:0]     colour;

  int vectors    = 0;
  int miscompares = 0;

  vga_glyph_string dut (
    .clk(clk), .reset(reset), .start(start), .glyphs(glyphs),
    .x(x), .y(y), .colour_in(colour_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .writeEn(writeEn), .colour(colour)
  );

  always #5 clk = ~clk;

  // {busy, done, writeEn, colour, x, y}
  function automatic logic [31:0] pk(input logic b, input logic d, input logic w,
                                     input logic [2:0] c, input logic [7:0] px,
                                     input logic [6:0] py);
    return {11'd0, b, d, w, c, px, py};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic full_clear();
    for (int py = 0; py < 120; py++)
      for (int px = 0; px < 160; px++) begin
        @(negedge clk);
        check($sformatf("fullclr(%0d,%0d)", px, py),
              pk(busy, done, writeEn, colour, x_out, y_out),
              pk(1'b1, 1'b0, 1'b1, 3'd0, 8'(px), 7'(py)));
      end
    @(negedge clk);
    check("fullclr_end", {29'd0, busy, done, writeEn}, 32'd0);
  endtask

  // Runs one string; abort_at > 0 pulls reset low after that output cycle.
  task automatic run_string(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                            input logic [P-1:0] g, input bit disturb, input int abort_at,
                            output int n_wr, output logic [14:0] last_xy);
    int j, k, r, c;
    logic b;
    n_wr = 0;
    last_xy = '0;
    x = x0; y = y0; colour_in = c0; glyphs = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_cycle0", {29'd0, busy, done, writeEn}, 32'd0);
    for (int n = 1; n <= 2 * P + 2; n++) begin
      @(negedge clk);
      if (n <= P) begin
        j = n - 1;
        check($sformatf("clear[%0d]", j), pk(busy, done, writeEn, colour, x_out, y_out),
              pk(1'b1, 1'b0, 1'b1, 3'd0, 8'(int'(x0) + j % BW), 7'(int'(y0) + j / BW)));
      end else if (n <= 2 * P) begin
        j = n - P - 1;
        k = j / 144; r = (j % 144) / 12; c = j % 12;
        b = g[P - 1 - j];
        check($sformatf("draw[%0d]", j), pk(busy, done, writeEn, colour, x_out, y_out),
              pk(1'b1, 1'b0, b, c0, 8'(int'(x0) + k * 12 + c), 7'(int'(y0) + r)));
        if (writeEn) begin
          n_wr++;
          last_xy = {x_out, y_out};
        end
      end else if (n == 2 * P + 1) begin
        check("done_pulse", {29'd0, busy, done, writeEn}, 32'b010);
      end else begin
        check("after_done", {29'd0, busy, done, writeEn}, 32'd0);
      end
      if (disturb && n == 600) begin
        start = 1'b1; x = ~x0; y = ~y0; colour_in = ~c0; glyphs = ~g;
      end
      if (disturb && n == 601) start = 1'b0;
      if (n == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        check("abort_zero", pk(busy, done, writeEn, colour, x_out, y_out), 32'd0);
        break;
      end
    end
    if (abort_at == 0) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("idle_after", {29'd0, busy, done, writeEn}, 32'd0);
      end
    end
  endtask

  initial begin
    int nw;
    logic [14:0] lxy;
    logic [P-1:0] g;
    reset = 1'b0; start = 1'b0; glyphs = '0; x = '0; y = '0; colour_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", pk(busy, done, writeEn, colour, x_out, y_out), 32'd0);
    reset = 1'b1;
    full_clear();

    // all bits set: 432 clears then 432 colour-5 writes, done at cycle 865
    g = '1;
    run_string(8'd10, 7'd20, 3'b101, g, 1'b0, 0, nw, lxy);
    check("all_ones_writes", 32'(nw), 32'd432);

    // only char 1's top-left pixel set
    g = '0;
    g[P - 1 - 144] = 1'b1;
    run_string(8'd10, 7'd20, 3'b011, g, 1'b0, 0, nw, lxy);
    check("single_bit_count", 32'(nw), 32'd1);
    check("single_bit_pos", 32'(lxy), 32'({8'd22, 7'd20}));

    // start re-pulsed mid-DRAW with changed inputs: stream unchanged
    g = {36{12'hA5C}};
    run_string(8'd30, 7'd40, 3'b110, g, 1'b1, 0, nw, lxy);
    check("disturb_writes", 32'(nw), 32'd216);

    // wrap in x and y
    g = {36{12'h3C9}};
    run_string(8'd150, 7'd100, 3'b001, g, 1'b0, 0, nw, lxy);
    run_string(8'd240, 7'd125, 3'b111, g, 1'b0, 0, nw, lxy);

    // reset at DRAW cycle 100, then full clear again
    g = '1;
    run_string(8'd5, 7'd5, 3'b010, g, 1'b0, P + 100, nw, lxy);
    reset = 1'b1;
    full_clear();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
